// File: rtl/iq_packer_pkg.sv
// Shared types and constants for the I/Q sample packer.
package iq_packer_pkg;

    localparam logic [15:0] HDR_MAGIC = 16'hA5C3;

    // Header field positions inside the 64-bit header word
    localparam int unsigned HDR_MAGIC_LSB = 48;
    localparam int unsigned HDR_SEQ_LSB   = 32;
    localparam int unsigned HDR_AUX_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_DROP
    } state_e;

    // One FIFO entry: packed data word plus end-of-frame marker
    typedef struct packed {
        logic        last;
        logic [63:0] data;
    } fifo_word_t;

    // Words per frame: one header plus four samples per data word
    function automatic int unsigned frame_words(input int unsigned num_chans,
                                                input int unsigned frame_sets);
        return 1 + (frame_sets * num_chans) / 2;
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous packet FIFO with first-word-fall-through output register.
// The output register mirrors the head entry, so level counts every held word.
module pkt_fifo
    import iq_packer_pkg::*;
#(
    parameter int unsigned AW = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  fifo_word_t wr_data,
    output fifo_word_t rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic [AW:0] level,
    output logic [AW:0] free
);

    localparam int unsigned DEPTH = 2 ** AW;

    fifo_word_t    mem [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW-1:0] rptr_n;
    logic [AW:0]   count_q;
    logic [AW:0]   count_n;
    logic          pop_c;
    logic          push_c;
    fifo_word_t    head_c;

    // Next occupancy and the entry that becomes the head after this cycle
    always_comb begin
        pop_c   = rd_valid && rd_ready;
        push_c  = wr_en && ((count_q != (AW+1)'(DEPTH)) || pop_c);
        count_n = count_q + (AW+1)'(push_c) - (AW+1)'(pop_c);
        rptr_n  = rptr_q + AW'(pop_c);
        if (push_c && (wptr_q == rptr_n)) begin
            head_c = wr_data;
        end else begin
            head_c = mem[rptr_n];
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
            level    <= '0;
            free     <= (AW+1)'(DEPTH);
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            wptr_q   <= wptr_q + AW'(push_c);
            rptr_q   <= rptr_n;
            count_q  <= count_n;
            level    <= count_n;
            free     <= (AW+1)'(DEPTH) - count_n;
            rd_valid <= (count_n != '0);
            if (count_n != '0) begin
                rd_data <= head_c;
            end
        end
    end

    // Admission control guarantees space; a write into a full FIFO is a design bug
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && (count_q == (AW+1)'(DEPTH)) && !pop_c))
        else $error("pkt_fifo: write while full");

endmodule

// File: rtl/iq_packer.sv
// Frames the channel-interleaved 16-bit I/Q stream into 64-bit AXI-Stream packets.
// Optional build macro IQ_PACKER_TIMESTAMP_EN: header low word carries an aclk
// cycle timestamp instead of the cumulative admitted-set count.
module iq_packer
    import iq_packer_pkg::*;
#(
    parameter int unsigned NUM_CHANS  = 13,
    parameter int unsigned FRAME_SETS = 32,
    parameter int unsigned FIFO_AW    = 9
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               en,
    input  logic [15:0]        s_tdata,
    input  logic               s_tvalid,
    input  logic [7:0]         s_tuser,
    output logic [63:0]        m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast,
    output logic [15:0]        drop_cnt,
    output logic [15:0]        sync_err_cnt,
    output logic [FIFO_AW:0]   fifo_level
);

    localparam int unsigned SAMPLES     = 2 * NUM_CHANS;
    localparam int unsigned FRAME_WORDS = frame_words(NUM_CHANS, FRAME_SETS);
    localparam int unsigned LW          = FIFO_AW + 2;
    localparam int unsigned SET_W       = $clog2(FRAME_SETS + 1);
    localparam logic [7:0]  IDX_LAST    = 8'(SAMPLES - 1);

    if (((FRAME_SETS * NUM_CHANS * 2) % 4) != 0) begin : g_bad_frame
        $error("iq_packer: FRAME_SETS*NUM_CHANS*2 must be divisible by 4");
    end
    if ((2 ** FIFO_AW) < FRAME_WORDS) begin : g_bad_depth
        $error("iq_packer: FIFO depth smaller than one frame");
    end

    state_e           state_q;
    logic [7:0]       exp_idx_q;
    logic [SET_W-1:0] set_cnt_q;
    logic [1:0]       lane_q;
    logic [47:0]      word_q;
    logic [15:0]      seq_q;
    logic             wr_en_q;
    fifo_word_t       wr_word_q;
    fifo_word_t       rd_word;
    logic [FIFO_AW:0] fifo_free;
    logic [31:0]      aux_q;

    logic             start_c;
    logic             match_c;
    logic             wrap_c;
    logic             final_c;
    logic             pop_c;
    logic             room_c;
    logic [63:0]      hdr_c;

`ifdef IQ_PACKER_TIMESTAMP_EN
    // Free-running cycle counter used as the header timestamp
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aux_q <= '0;
        end else begin
            aux_q <= aux_q + 32'd1;
        end
    end
`else
    // Cumulative count of sets admitted, advanced by a full frame on each admit
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aux_q <= '0;
        end else if ((state_q == ST_IDLE) && start_c && en && room_c) begin
            aux_q <= aux_q + 32'(FRAME_SETS);
        end
    end
`endif

    // Index tracking, admission check and header assembly
    always_comb begin
        start_c = s_tvalid && (s_tuser == 8'd0);
        match_c = (s_tuser == exp_idx_q);
        wrap_c  = (exp_idx_q == IDX_LAST);
        final_c = wrap_c && (set_cnt_q == SET_W'(FRAME_SETS - 1));
        pop_c   = m_axis_tvalid && m_axis_tready;
        // Post-read free space must hold the whole frame plus any write still in flight
        room_c  = ({1'b0, fifo_free} + LW'(pop_c)) >= (LW'(FRAME_WORDS) + LW'(wr_en_q));
        hdr_c   = '0;
        hdr_c[HDR_MAGIC_LSB +: 16] = HDR_MAGIC;
        hdr_c[HDR_SEQ_LSB +: 16]   = seq_q;
        hdr_c[HDR_AUX_LSB +: 32]   = aux_q;
    end

    // Framing FSM, lane packer, counters and registered FIFO write port
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            exp_idx_q    <= '0;
            set_cnt_q    <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            seq_q        <= '0;
            drop_cnt     <= '0;
            sync_err_cnt <= '0;
            wr_en_q      <= 1'b0;
            wr_word_q    <= '0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_c && en) begin
                        seq_q     <= seq_q + 16'd1;
                        exp_idx_q <= 8'd1;
                        set_cnt_q <= '0;
                        if (!room_c) begin
                            drop_cnt <= (drop_cnt == 16'hFFFF) ? drop_cnt : drop_cnt + 16'd1;
                            state_q  <= ST_DROP;
                        end else begin
                            wr_en_q        <= 1'b1;
                            wr_word_q.last <= 1'b0;
                            wr_word_q.data <= hdr_c;
                            word_q         <= {32'h0, s_tdata};
                            lane_q         <= 2'd1;
                            state_q        <= ST_FILL;
                        end
                    end
                end
                ST_FILL: begin
                    if (s_tvalid) begin
                        if (!match_c) begin
                            // Truncate: flush pending lanes zero-padded, discard the stray sample
                            sync_err_cnt   <= (sync_err_cnt == 16'hFFFF) ? sync_err_cnt
                                                                         : sync_err_cnt + 16'd1;
                            wr_en_q        <= 1'b1;
                            wr_word_q.last <= 1'b1;
                            wr_word_q.data <= {16'h0, word_q};
                            word_q         <= '0;
                            lane_q         <= '0;
                            state_q        <= ST_IDLE;
                        end else begin
                            exp_idx_q <= wrap_c ? 8'd0 : exp_idx_q + 8'd1;
                            if (wrap_c) begin
                                set_cnt_q <= set_cnt_q + SET_W'(1);
                            end
                            if (lane_q == 2'd3) begin
                                wr_en_q        <= 1'b1;
                                wr_word_q.last <= final_c;
                                wr_word_q.data <= {s_tdata, word_q};
                                word_q         <= '0;
                                lane_q         <= '0;
                            end else begin
                                word_q[{lane_q, 4'b0000} +: 16] <= s_tdata;
                                lane_q <= lane_q + 2'd1;
                            end
                            if (final_c) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_DROP: begin
                    if (s_tvalid) begin
                        if (!match_c) begin
                            // Lost alignment: resynchronise on the next index 0
                            sync_err_cnt <= (sync_err_cnt == 16'hFFFF) ? sync_err_cnt
                                                                       : sync_err_cnt + 16'd1;
                            state_q      <= ST_IDLE;
                        end else begin
                            exp_idx_q <= wrap_c ? 8'd0 : exp_idx_q + 8'd1;
                            if (wrap_c) begin
                                set_cnt_q <= set_cnt_q + SET_W'(1);
                            end
                            if (final_c) begin
                                state_q <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    pkt_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk      (aclk),
        .rst_n    (aresetn),
        .wr_en    (wr_en_q),
        .wr_data  (wr_word_q),
        .rd_data  (rd_word),
        .rd_valid (m_axis_tvalid),
        .rd_ready (m_axis_tready),
        .level    (fifo_level),
        .free     (fifo_free)
    );

    assign m_axis_tdata = rd_word.data;
    assign m_axis_tlast = rd_word.last;

endmodule
